// File: rtl/delay_timer_bank.sv
// Bank of independent down-counting delay timers with registered flags, runtime load,
// one-shot/periodic mode, global pause and an all-done indicator.
module delay_timer_bank #(
  parameter int CHANNELS      = 4,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_DELAY = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       cfg_load,
  input  logic [CHANNELS*CNT_W-1:0] cfg_delay,
  input  logic [CHANNELS-1:0]       cfg_periodic,
  input  logic                      pause,
  output logic [CHANNELS-1:0]       d,
  output logic                      done_all
);

  localparam logic [CNT_W-1:0] DEF_DELAY = CNT_W'(DEFAULT_DELAY);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0]    cnt    [CHANNELS];
  logic [CNT_W-1:0]    reload [CHANNELS];
  logic [CHANNELS-1:0] periodic;
  logic [CHANNELS-1:0] running;
  logic [CHANNELS-1:0] done;

  // NOTE: all state here is sequential and uses non-blocking assignments, so every
  // channel sees the pre-edge value of its own counter regardless of loop order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        cnt[i]      <= DEF_DELAY;
        reload[i]   <= DEF_DELAY;
        periodic[i] <= 1'b0;
        running[i]  <= (DEF_DELAY != '0);
        done[i]     <= (DEF_DELAY == '0);
        d[i]        <= 1'b0;
      end else if (cfg_load[i]) begin
        cnt[i]      <= cfg_delay[i*CNT_W +: CNT_W];
        reload[i]   <= cfg_delay[i*CNT_W +: CNT_W];
        periodic[i] <= cfg_periodic[i];
        running[i]  <= (cfg_delay[i*CNT_W +: CNT_W] != '0);
        done[i]     <= (cfg_delay[i*CNT_W +: CNT_W] == '0);
        d[i]        <= 1'b0;
      end else if (!pause && running[i]) begin
        if (cnt[i] > ONE) begin
          cnt[i] <= cnt[i] - ONE;
          // A periodic pulse lasts one counting cycle; one-shot d is sticky.
          if (periodic[i]) d[i] <= 1'b0;
        end else begin
          d[i]    <= 1'b1;
          done[i] <= 1'b1;
          if (periodic[i]) cnt[i] <= reload[i];
          else             running[i] <= 1'b0;
        end
      end
    end
  end

  assign done_all = &done;

endmodule

// File: tb/tb_delay_timer_bank.sv
// Self-checking bench for delay_timer_bank: directed scenarios plus randomized traffic,
// compared each cycle against an elapsed-time reference model.
module tb_delay_timer_bank;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int DEF = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   cfg_load;
  logic [CH*W-1:0] cfg_delay;
  logic [CH-1:0]   cfg_periodic;
  logic            pause;
  logic [CH-1:0]   d;
  logic            done_all;

  int errors = 0;
  int checks = 0;

  // Reference: each channel is described by its delay, mode and the number of
  // un-paused edges since its last reset/load edge.
  int m_delay [CH];
  int m_per   [CH];
  int m_el    [CH];

  delay_timer_bank #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DELAY(DEF)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .cfg_periodic(cfg_periodic), .pause(pause), .d(d), .done_all(done_all)
  );

  always #5 clk = ~clk;

  function automatic logic exp_d(int i);
    if (m_delay[i] == 0 || m_el[i] < m_delay[i]) return 1'b0;
    if (m_per[i] != 0) return (m_el[i] % m_delay[i]) == 0;
    return 1'b1;
  endfunction

  function automatic logic exp_done(int i);
    return (m_delay[i] == 0) || (m_el[i] >= m_delay[i]);
  endfunction

  task automatic model_update();
    for (int i = 0; i < CH; i++) begin
      if (reset) begin
        m_delay[i] = DEF; m_per[i] = 0; m_el[i] = 0;
      end else if (cfg_load[i]) begin
        m_delay[i] = int'(cfg_delay[i*W +: W]);
        m_per[i]   = int'(cfg_periodic[i]);
        m_el[i]    = 0;
      end else if (!pause) begin
        m_el[i] = m_el[i] + 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [CH-1:0] ed;
    logic          ea;
    ea = 1'b1;
    for (int i = 0; i < CH; i++) begin
      ed[i] = exp_d(i);
      ea    = ea & exp_done(i);
    end
    chk("model_d", 32'(d), 32'(ed));
    chk("model_done_all", 32'(done_all), 32'(ea));
  endtask

  // One clock edge: update the model from the sampled inputs, then compare just after.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic set_load(int ch, int dly, logic per);
    cfg_load[ch]          = 1'b1;
    cfg_delay[ch*W +: W]  = W'(dly);
    cfg_periodic[ch]      = per;
  endtask

  task automatic clr_load();
    cfg_load = '0;
  endtask

  initial begin
    reset = 1'b1; cfg_load = '0; cfg_delay = '0; cfg_periodic = '0; pause = 1'b0;

    // 1: reset and default release
    step(); step();
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_done_all", 32'(done_all), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    chk("dflt_before", 32'(d), 32'h0);
    step();
    chk("dflt_d", 32'(d), 32'hF);
    chk("dflt_done_all", 32'(done_all), 32'h1);

    // 2: ch1 periodic delay 3
    set_load(1, 3, 1'b1); step(); clr_load();
    chk("per_load_d1", 32'(d[1]), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("per_d1", 32'(d[1]), (k % 3 == 0) ? 32'h1 : 32'h0);
    end

    // 3: ch2 disabled with delay 0
    set_load(2, 0, 1'b0); step(); clr_load();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("dis_d2", 32'(d[2]), 32'h0);
    end
    chk("dis_done_all", 32'(done_all), 32'h1);

    // 4: ch0 delay 10 with a 5-cycle pause after edge +4
    set_load(0, 10, 1'b0); step(); clr_load();
    for (int k = 0; k < 4; k++) step();
    pause = 1'b1;
    for (int k = 0; k < 5; k++) step();
    pause = 1'b0;
    for (int k = 10; k <= 14; k++) begin
      step();
      chk("pause_d0_low", 32'(d[0]), 32'h0);
    end
    step();
    chk("pause_d0_rise", 32'(d[0]), 32'h1);

    // 5: ch3 reloaded mid-count
    set_load(3, 8, 1'b0); step(); clr_load();
    for (int k = 0; k < 4; k++) step();
    set_load(3, 2, 1'b0); step(); clr_load();
    chk("reload_d3_e5", 32'(d[3]), 32'h0);
    step();
    chk("reload_d3_e6", 32'(d[3]), 32'h0);
    step();
    chk("reload_d3_e7", 32'(d[3]), 32'h1);

    // 6: reset mid-count with concurrent loads
    set_load(0, 5, 1'b0); step(); clr_load();
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < CH; i++) set_load(i, 1, 1'b1);
    step();
    chk("rst_mid_d", 32'(d), 32'h0);
    reset = 1'b0; clr_load();
    for (int k = 1; k <= 7; k++) step();
    chk("rst_mid_before", 32'(d), 32'h0);
    step();
    chk("rst_mid_after", 32'(d), 32'hF);

    // Maximum delay, one-shot, no wrap
    set_load(0, 255, 1'b0); step(); clr_load();
    for (int k = 1; k <= 254; k++) step();
    chk("max_before", 32'(d[0]), 32'h0);
    step();
    chk("max_rise", 32'(d[0]), 32'h1);

    // Periodic delay 1: continuously high
    set_load(1, 1, 1'b1); step(); clr_load();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("per1_d1", 32'(d[1]), 32'h1);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      pause = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < CH; i++) begin
        cfg_load[i]         = ($urandom_range(0, 15) == 0);
        cfg_delay[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
        cfg_periodic[i]     = 1'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
